// File: rtl/wb_commit_queue.sv
// In-order writeback commit queue between MEM and WB.
// Accepts one entry per cycle from MEM and retires at most one per cycle to the
// register file, CP0 and the debug trace. Retiring an exception or eret flushes
// the pipeline and discards every younger queued entry. Queued GPR writes are
// forwarded youngest-first to decode on two read ports.
module wb_commit_queue #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RA_W   = 5,
  parameter int unsigned EXC_W  = 5
) (
  input  logic              clk,
  input  logic              resetn,
  // MEM -> WB entry
  input  logic              ms_to_ws_valid,
  output logic              ws_allowin,
  input  logic [DATA_W-1:0] ms_pc,
  input  logic [DATA_W-1:0] ms_result,
  input  logic [DATA_W-1:0] ms_rt_value,
  input  logic [DATA_W-1:0] ms_badvaddr,
  input  logic [RA_W-1:0]   ms_dest,
  input  logic              ms_gr_we,
  input  logic              ms_ex,
  input  logic              ms_eret,
  input  logic              ms_bd,
  input  logic              ms_mtc0_we,
  input  logic              ms_res_from_cp0,
  input  logic [EXC_W-1:0]  ms_excode,
  input  logic [4:0]        ms_cp0_addr,
  // register file / CP0
  input  logic              rf_ready,
  input  logic [DATA_W-1:0] cp0_rdata,
  output logic [4:0]        cp0_raddr,
  output logic              rf_we,
  output logic [RA_W-1:0]   rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              cp0_ex,
  output logic [EXC_W-1:0]  cp0_excode,
  output logic [DATA_W-1:0] cp0_badvaddr,
  output logic              cp0_bd,
  output logic [DATA_W-1:0] cp0_epc_pc,
  output logic              cp0_mtc0_we,
  output logic [4:0]        cp0_waddr,
  output logic [DATA_W-1:0] cp0_wdata,
  output logic              cp0_eret,
  output logic              ws_flush,
  // forwarding to decode
  input  logic [RA_W-1:0]   fwd_raddr0,
  input  logic [RA_W-1:0]   fwd_raddr1,
  output logic              fwd_hit0,
  output logic              fwd_hit1,
  output logic              fwd_pend0,
  output logic              fwd_pend1,
  output logic [DATA_W-1:0] fwd_data0,
  output logic [DATA_W-1:0] fwd_data1,
  // debug trace
  output logic [DATA_W-1:0] debug_wb_pc,
  output logic [3:0]        debug_wb_rf_wen,
  output logic [RA_W-1:0]   debug_wb_rf_wnum,
  output logic [DATA_W-1:0] debug_wb_rf_wdata
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DepthCnt = CW'(DEPTH);

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] rt_value;
    logic [DATA_W-1:0] badvaddr;
    logic [RA_W-1:0]   dest;
    logic              gr_we;
    logic              ex;
    logic              eret;
    logic              bd;
    logic              mtc0_we;
    logic              res_from_cp0;
    logic [EXC_W-1:0]  excode;
    logic [4:0]        cp0_addr;
  } entry_t;

  entry_t           mem_q [DEPTH];
  entry_t           mem_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;

  entry_t head_e;
  logic   not_empty;
  logic   retire;
  logic   push;
  logic   flush;

  assign head_e    = mem_q[head_q];
  assign not_empty = (count_q != '0);
  // Allowin depends only on registered count: no pop-to-allowin path.
  assign ws_allowin = (count_q < DepthCnt);
  assign retire    = not_empty && (rf_ready || !head_e.gr_we || head_e.ex);
  assign push      = ms_to_ws_valid && ws_allowin;

  // Commit strobes and data for the head entry; strobes are gated by retire.
  always_comb begin
    rf_we        = retire && head_e.gr_we && !head_e.ex;
    rf_waddr     = head_e.dest;
    rf_wdata     = head_e.res_from_cp0 ? cp0_rdata : head_e.result;
    cp0_raddr    = head_e.cp0_addr;
    cp0_ex       = retire && head_e.ex;
    cp0_excode   = head_e.excode;
    cp0_badvaddr = head_e.badvaddr;
    cp0_bd       = head_e.bd;
    cp0_epc_pc   = head_e.pc;
    cp0_mtc0_we  = retire && head_e.mtc0_we && !head_e.ex;
    cp0_waddr    = head_e.cp0_addr;
    cp0_wdata    = head_e.rt_value;
    cp0_eret     = retire && head_e.eret && !head_e.ex;
    flush        = cp0_ex || cp0_eret;
    ws_flush     = flush;

    debug_wb_pc       = head_e.pc;
    debug_wb_rf_wen   = {4{rf_we}};
    debug_wb_rf_wnum  = head_e.dest;
    debug_wb_rf_wdata = rf_wdata;
  end

  // Youngest-match forwarding: walk oldest to youngest so later matches override.
  always_comb begin
    logic [PW-1:0] idx;
    fwd_hit0  = 1'b0;
    fwd_pend0 = 1'b0;
    fwd_data0 = '0;
    fwd_hit1  = 1'b0;
    fwd_pend1 = 1'b0;
    fwd_data1 = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (valid_q[idx] && mem_q[idx].gr_we && !mem_q[idx].ex && (mem_q[idx].dest != '0)) begin
        if (mem_q[idx].dest == fwd_raddr0) begin
          fwd_hit0  = 1'b1;
          fwd_pend0 = mem_q[idx].res_from_cp0;
          fwd_data0 = mem_q[idx].result;
        end
        if (mem_q[idx].dest == fwd_raddr1) begin
          fwd_hit1  = 1'b1;
          fwd_pend1 = mem_q[idx].res_from_cp0;
          fwd_data1 = mem_q[idx].result;
        end
      end
    end
  end

  // Queue next state: flush discards everything including a same-cycle push.
  always_comb begin
    mem_d   = mem_q;
    valid_d = valid_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      valid_d = '0;
      count_d = '0;
      head_d  = tail_q;
    end else begin
      if (push) begin
        mem_d[tail_q] = '{
          pc:           ms_pc,
          result:       ms_result,
          rt_value:     ms_rt_value,
          badvaddr:     ms_badvaddr,
          dest:         ms_dest,
          gr_we:        ms_gr_we,
          ex:           ms_ex,
          eret:         ms_eret,
          bd:           ms_bd,
          mtc0_we:      ms_mtc0_we,
          res_from_cp0: ms_res_from_cp0,
          excode:       ms_excode,
          cp0_addr:     ms_cp0_addr
        };
        valid_d[tail_q] = 1'b1;
        tail_d          = tail_q + 1'b1;
      end
      if (retire) begin
        valid_d[head_q] = 1'b0;
        head_d          = head_q + 1'b1;
      end
      count_d = count_q + CW'(push) - CW'(retire);
    end
  end

  // Queue state registers; payload is cleared too so head fields are never X.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      valid_q <= valid_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule
